inst_queue: RTL
===============

# inst_queue

Instruction queue between fetch and the decode stage. Fetch pushes one {pc, inst} pair per cycle. Decode pops the head entry and splits it into opcode, funct, register and immediate fields. The queue absorbs fetch/decode rate mismatch and is emptied in one cycle on a pipeline flush (branch mispredict or exception redirect).

## Interface
- DEPTH, 16, number of entries; power of two, ≥ 2.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  discard all entries at the next edge.
- enq_valid  input  1  fetch presents an entry.
- enq_ready  output  1  queue can accept; equals !full.
- enq_inst  input  32  instruction word.
- enq_pc  input  32  PC of enq_inst.
- deq_valid  output  1  head entry valid; equals !empty.
- deq_ready  input  1  decode consumes the head this cycle.
- deq_inst  output  32  head instruction word; 32'h0000_0013 (NOP) when empty.
- deq_pc  output  32  head PC; 32'h0 when empty.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage
  - Circular buffer of DEPTH entries, each 64 bits {pc, inst}.
  - head and tail pointers are $clog2(DEPTH)+1 bits wide. The MSB is the wrap bit.
  - empty = (head == tail).
  - full = (index bits equal) && (wrap bits differ).
  - count = tail − head, computed modulo 2^($clog2(DEPTH)+1).
- Transfer rules
  - Enqueue fires when enq_valid && enq_ready.
    - Entry is written at tail[index].
    - tail increments. The index wraps DEPTH−1 → 0 and the wrap bit toggles.
  - Dequeue fires when deq_valid && deq_ready.
    - head increments with the same wrap rule.
  - Simultaneous enqueue and dequeue (not full, not empty): both fire and count is unchanged.
- Boundary conditions
  - Full: enq_ready is 0 even if a dequeue fires in the same cycle. No same-cycle pass-through of free space. The freed slot is usable the next cycle.
  - Empty: no bypass. An entry enqueued at edge N is visible on deq_* only after edge N. deq_ready while empty has no effect.
- Head outputs
  - deq_inst and deq_pc are a combinational read of the buffer at head[index].
  - When empty, the outputs are forced to the NOP and zero values listed under Interface.
- Flush
  - Highest priority below reset.
  - When flush = 1 at an edge: head and tail are both set to 0, and any same-cycle enqueue or dequeue is discarded.
  - Buffer contents are not cleared.
- Reset
  - When rst_n = 0 at an edge: head = tail = 0.
  - Outputs after reset: enq_ready = 1, deq_valid = 0, count = 0, deq_inst = 32'h0000_0013, deq_pc = 0.
  - A reset asserted mid-operation behaves identically: all entries are dropped.
  - Buffer RAM is not reset.
- Priority at each edge: rst_n low > flush > enqueue/dequeue.

## Timing
- enq_ready, deq_valid and count are functions of registered pointers only. There is no combinational path from enq_valid or deq_ready to any output.
- Latency from enqueue to visibility at the head of an empty queue: 1 cycle.
- Throughput: 1 enqueue and 1 dequeue per cycle sustained when 0 < count < DEPTH.
- After a flush edge:
  - deq_valid = 0 and enq_ready = 1 in the following cycle.
  - A new enqueue is accepted in that following cycle.
- Handshake is valid/ready.
  - Fetch holds enq_inst/enq_pc stable while enq_valid && !enq_ready.
  - The queue holds deq_* stable while deq_valid && !deq_ready.

## Test plan
- Reset, then single pass:
  - Release rst_n.
  - Enqueue {pc=0x0000_1000, inst=0x0010_0093} with deq_ready = 0.
  - Next cycle: deq_valid = 1, deq_inst = 0x0010_0093, deq_pc = 0x1000, count = 1.
  - Pulse deq_ready: count = 0 and deq_inst = 0x0000_0013.
- Fill to full (DEPTH = 16):
  - Enqueue 16 entries with pc = 0x1000 + 4i and deq_ready = 0.
  - Expect count = 16 and enq_ready = 0.
  - Assert enq_valid for 3 more cycles: count stays 16.
  - Drain all 16: PCs come out in order 0x1000..0x103C.
- Full with simultaneous enq/deq:
  - At count = 16, assert enq_valid and deq_ready together.
  - Only the dequeue fires, count = 15.
  - Next cycle enq_ready = 1. The next enqueue lands behind 0x103C.
- Wrap-around:
  - Stream 40 entries with enq_valid = 1 and deq_ready = 1 every cycle from empty.
  - Order is preserved.
  - count never exceeds 1 once steady state is reached.
  - deq_pc follows enq_pc delayed by 1 cycle across both pointer wraps.
- Flush:
  - With count = 7, assert flush together with enq_valid and deq_ready.
  - Next cycle: count = 0, deq_valid = 0, enq_ready = 1.
  - The entry presented during flush never appears on deq_*.
- Reset mid-stream:
  - With count = 5, drive rst_n = 0 for 1 cycle.
  - Expect count = 0, deq_valid = 0, enq_ready = 1.
  - A new enqueue {pc=0x2000} is the first entry dequeued.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular buffer of {pc, inst}
// pairs with wrap-bit pointers, single-cycle flush and a NOP when empty.
module inst_queue #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [31:0]              enq_inst,
    input  logic [31:0]              enq_pc,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [31:0]              deq_inst,
    output logic [31:0]              deq_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Handshake: a transfer happens on an edge where valid && ready are both
    // high; ready/valid outputs depend on registered pointers only.

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic          empty, full;
    logic          enq_fire, deq_fire;
    logic [63:0]   head_entry;

    assign empty     = (head_q == tail_q);
    assign full      = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign count     = tail_q - head_q;

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;

    assign head_entry = mem_q[head_q[AW-1:0]];
    assign deq_inst   = empty ? NOP_INST : head_entry[31:0];
    assign deq_pc     = empty ? 32'h0   : head_entry[63:32];

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + PW'(1);
            if (deq_fire) head_d = head_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Storage is deliberately left out of reset and flush; pointers define validity.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && enq_fire) begin
            mem_q[tail_q[AW-1:0]] <= {enq_pc, enq_inst};
        end
    end

endmodule
